// File: rtl/barrido_mux16.sv
// barrido_mux16: steps the 4-bit select of a 16:1 mux through 0..15, samples Y at each index
// and publishes the assembled word. Define BARRIDO_PARIDAD_EN to add the parity outputs.
module barrido_mux16 #(
    parameter int PASO_CICLOS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Inicio,
    input  logic        Continuo,
    input  logic        Abortar,
    input  logic        Y,
`ifdef BARRIDO_PARIDAD_EN
    input  logic        ParidadEsperada,
    output logic        Paridad,
    output logic        ErrorParidad,
`endif
    output logic [3:0]  Seleccion,
    output logic        Ocupado,
    output logic        Listo,
    output logic [15:0] Dato
);

    // state   | meaning
    // REPOSO  | idle, waiting for Inicio
    // BARRIDO | holding Seleccion PASO_CICLOS cycles, then sampling Y
    // FIN     | publish Dato, pulse Listo, rescan if Continuo
    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        BARRIDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    localparam logic [3:0] CNT_FIN = 4'(PASO_CICLOS - 1);

    estado_t     estado;
    logic [3:0]  cnt;
    logic [15:0] captura;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= REPOSO;
            cnt          <= 4'd0;
            captura      <= 16'h0000;
            Seleccion    <= 4'd0;
            Ocupado      <= 1'b0;
            Listo        <= 1'b0;
            Dato         <= 16'h0000;
`ifdef BARRIDO_PARIDAD_EN
            Paridad      <= 1'b0;
            ErrorParidad <= 1'b0;
`endif
        end else begin
            Listo        <= 1'b0;
`ifdef BARRIDO_PARIDAD_EN
            ErrorParidad <= 1'b0;
`endif
            unique case (estado)
                REPOSO: begin
                    if (Inicio) begin
                        estado    <= BARRIDO;
                        Seleccion <= 4'd0;
                        cnt       <= 4'd0;
                        captura   <= 16'h0000;
                        Ocupado   <= 1'b1;
                    end
                end
                BARRIDO: begin
                    // Abort wins over the capture that would happen on this edge
                    if (Abortar) begin
                        estado    <= REPOSO;
                        Seleccion <= 4'd0;
                        Ocupado   <= 1'b0;
                    end else if (cnt == CNT_FIN) begin
                        captura[Seleccion] <= Y;
                        if (Seleccion == 4'd15) begin
                            estado  <= FIN;
                            Ocupado <= 1'b0;
                        end else begin
                            Seleccion <= Seleccion + 4'd1;
                            cnt       <= 4'd0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FIN: begin
                    Dato      <= captura;
                    Listo     <= 1'b1;
                    Seleccion <= 4'd0;
`ifdef BARRIDO_PARIDAD_EN
                    Paridad      <= ^captura;
                    ErrorParidad <= (^captura) != ParidadEsperada;
`endif
                    if (Continuo) begin
                        estado  <= BARRIDO;
                        cnt     <= 4'd0;
                        captura <= 16'h0000;
                        Ocupado <= 1'b1;
                    end else begin
                        estado <= REPOSO;
                    end
                end
                default: begin
                    estado    <= REPOSO;
                    Seleccion <= 4'd0;
                    Ocupado   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrido_mux16.sv
// Bench for barrido_mux16: two instances (PASO_CICLOS 1 and 3) share stimulus and are each
// compared every cycle against an elapsed-edge model of the scan, plus literal spot checks.
module tb_barrido_mux16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic        continuo = 1'b0;
    logic        abortar = 1'b0;
    logic [15:0] dn = 16'h0000;
    logic        par_esp = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int P = (g == 0) ? 1 : 3;

        logic [3:0]  seleccion;
        logic        ocupado, listo, y;
        logic [15:0] dato;
        logic        paridad, error_paridad;

        assign y = dn[seleccion];

`ifdef BARRIDO_PARIDAD_EN
        barrido_mux16 #(.PASO_CICLOS(P)) dut (
            .clk(clk), .rst_n(rst_n), .Inicio(inicio), .Continuo(continuo),
            .Abortar(abortar), .Y(y), .ParidadEsperada(par_esp),
            .Paridad(paridad), .ErrorParidad(error_paridad),
            .Seleccion(seleccion), .Ocupado(ocupado), .Listo(listo), .Dato(dato)
        );
`else
        assign paridad = 1'b0;
        assign error_paridad = 1'b0;
        barrido_mux16 #(.PASO_CICLOS(P)) dut (
            .clk(clk), .rst_n(rst_n), .Inicio(inicio), .Continuo(continuo),
            .Abortar(abortar), .Y(y),
            .Seleccion(seleccion), .Ocupado(ocupado), .Listo(listo), .Dato(dato)
        );
`endif

        // Model: e = edges elapsed since the start edge. Edges 1..16P are hold/sample edges,
        // bit i is taken at edge (i+1)*P, edge 16P+1 publishes the word.
        int          e = 0;
        bit          active = 1'b0;
        logic [15:0] word = 16'h0000;
        logic [3:0]  m_sel = 4'd0;
        logic        m_ocu = 1'b0, m_listo = 1'b0, m_par = 1'b0, m_err = 1'b0;
        logic [15:0] m_dato = 16'h0000;

        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    active = 1'b0; e = 0; word = 16'h0000;
                    m_dato = 16'h0000; m_listo = 1'b0; m_par = 1'b0; m_err = 1'b0;
                end else begin
                    m_listo = 1'b0;
                    m_err   = 1'b0;
                    if (active) begin
                        e = e + 1;
                        if (e <= 16 * P) begin
                            if (abortar) active = 1'b0;
                            else if (e % P == 0) word[(e / P) - 1] = dn[(e / P) - 1];
                        end else begin
                            m_dato  = word;
                            m_listo = 1'b1;
                            m_par   = ^word;
                            m_err   = (^word) != par_esp;
                            if (continuo) begin
                                e = 0; word = 16'h0000;
                            end else begin
                                active = 1'b0;
                            end
                        end
                    end else if (inicio) begin
                        active = 1'b1; e = 0; word = 16'h0000;
                    end
                end
                m_ocu = active && (e < 16 * P);
                m_sel = !active ? 4'd0 : ((e < 16 * P) ? 4'(e / P) : 4'd15);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("sel0", 32'(u[0].seleccion), 32'(u[0].m_sel));
            check("ocu0", 32'(u[0].ocupado),   32'(u[0].m_ocu));
            check("lst0", 32'(u[0].listo),     32'(u[0].m_listo));
            check("dat0", 32'(u[0].dato),      32'(u[0].m_dato));
            check("sel1", 32'(u[1].seleccion), 32'(u[1].m_sel));
            check("ocu1", 32'(u[1].ocupado),   32'(u[1].m_ocu));
            check("lst1", 32'(u[1].listo),     32'(u[1].m_listo));
            check("dat1", 32'(u[1].dato),      32'(u[1].m_dato));
`ifdef BARRIDO_PARIDAD_EN
            check("par0", 32'(u[0].paridad),       32'(u[0].m_par));
            check("err0", 32'(u[0].error_paridad), 32'(u[0].m_err));
            check("par1", 32'(u[1].paridad),       32'(u[1].m_par));
            check("err1", 32'(u[1].error_paridad), 32'(u[1].m_err));
`endif
        end
    end

    // Single scan from idle; k counts edges after the start edge (k=0).
    task automatic scan(input logic [15:0] d, output int k0, output int k1);
        k0 = -1;
        k1 = -1;
        dn = d;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        check("start_sel", 32'(u[0].seleccion), 32'd0);
        check("start_ocu", 32'(u[0].ocupado), 32'd1);
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k <= 15) check("step_sel", 32'(u[0].seleccion), 32'(k));
            if (u[0].listo && k0 < 0) k0 = k;
            if (u[1].listo && k1 < 0) k1 = k;
        end
    endtask

    initial begin
        int k0, k1, first, second;
        bit seen_listo;

        #1 check("rst_sel", 32'(u[0].seleccion), 32'd0);
        check("rst_dato", 32'(u[0].dato), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        scan(16'hA5C3, k0, k1);
        check("lat_p1", 32'(k0), 32'd17);
        check("lat_p3", 32'(k1), 32'd49);
        check("dato_a5c3_p1", 32'(u[0].dato), 32'h0000A5C3);
        check("dato_a5c3_p3", 32'(u[1].dato), 32'h0000A5C3);

        scan(16'h8001, k0, k1);
        check("lat_p3_b", 32'(k1), 32'd49);
        check("dato_8001_p3", 32'(u[1].dato), 32'h00008001);
        check("dato_8001_p1", 32'(u[0].dato), 32'h00008001);

`ifdef BARRIDO_PARIDAD_EN
        par_esp = 1'b0;
        dn = 16'h0007;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (17) @(negedge clk);
        check("par_0007", 32'(u[0].paridad), 32'd1);
        check("perr_pulse", 32'(u[0].error_paridad), 32'd1);
        repeat (100) @(negedge clk);
        par_esp = 1'b1;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (17) @(negedge clk);
        check("perr_none", 32'(u[0].error_paridad), 32'd0);
        check("listo_par", 32'(u[0].listo), 32'd1);
        repeat (100) @(negedge clk);
        par_esp = 1'b0;
`endif

        // Continuous mode: data changes in the FIN cycle between passes
        first = -1;
        second = -1;
        continuo = 1'b1;
        dn = 16'h00FF;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 16) begin
                check("fin_ocu_low", 32'(u[0].ocupado), 32'd0);
                dn = 16'hFF00;
            end
            if (k == 17) begin
                check("rescan_ocu", 32'(u[0].ocupado), 32'd1);
                continuo = 1'b0;
            end
            if (u[0].listo) begin
                if (first < 0) begin
                    first = k;
                    check("cont_dato1", 32'(u[0].dato), 32'h000000FF);
                end else if (second < 0) begin
                    second = k;
                    check("cont_dato2", 32'(u[0].dato), 32'h0000FF00);
                end
            end
        end
        check("cont_gap", 32'(second - first), 32'd17);

        // Abort at Seleccion=9 with 1234 already published
        scan(16'h1234, k0, k1);
        dn = 16'hFFFF;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        seen_listo = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            inicio = (k == 5);
        end
        inicio = 1'b0;
        check("abort_at_sel", 32'(u[0].seleccion), 32'd9);
        abortar = 1'b1;
        @(negedge clk);
        abortar = 1'b0;
        check("abort_ocu", 32'(u[0].ocupado), 32'd0);
        check("abort_sel", 32'(u[0].seleccion), 32'd0);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (u[0].listo || u[1].listo) seen_listo = 1'b1;
        end
        check("abort_no_listo", 32'(seen_listo), 32'd0);
        check("abort_dato", 32'(u[0].dato), 32'h00001234);

        // Asynchronous reset mid-scan
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_sel", 32'(u[0].seleccion), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(u[0].seleccion), 32'd0);
        check("arst_ocu", 32'(u[0].ocupado), 32'd0);
        check("arst_listo", 32'(u[0].listo), 32'd0);
        check("arst_dato", 32'(u[0].dato), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ocu", 32'(u[0].ocupado), 32'd0);

        // Randomized traffic, checked by the per-cycle compare
        for (int c = 0; c < 4000; c++) begin
            inicio   = ($urandom_range(0, 7) == 0);
            abortar  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) continuo = ~continuo;
            if ($urandom_range(0, 19) == 0) dn = 16'($urandom);
            par_esp  = 1'($urandom);
            @(negedge clk);
        end
        inicio = 1'b0;
        abortar = 1'b0;
        continuo = 1'b0;
        repeat (120) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
